puf_resp_reader: RTL and testbench

- Consumer side of two PUF ring-oscillator/counter pairs.
- Runs on the system clock. It drives the enable and counter reset of both pairs, waits for both count-valid flags, and samples the two counts.
- Each comparison yields one response bit. RESP_BITS bits are assembled into a word and offered on a valid/ready output.
- It is the system-clock reader of the RO-clocked counter outputs. All PUF-side inputs are asynchronous to clk.

---
 rtl/puf_resp_reader.sv | 185 ++++++++++++++++++
 tb/tb_puf_resp_reader.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_resp_reader.sv
// puf_resp_reader: system-clock reader for two PUF ring-oscillator/counter pairs.
// Each evaluation clears both counters, enables them, waits for both count-valid
// flags (2-flop synchronised), captures the counts and derives one response bit
// (count_a > count_b). RESP_BITS bits form a word offered on a valid/ready output.
module puf_resp_reader #(
  parameter int unsigned CNT_BIT_SIZE = 5,
  parameter int unsigned RESP_BITS    = 8,
  parameter int unsigned CLR_CYCLES   = 2,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  output logic                    o_busy,
  output logic                    o_puf_en,
  output logic                    o_puf_rst_n,
  input  logic                    i_valid_a,
  input  logic [CNT_BIT_SIZE-1:0] i_count_a,
  input  logic                    i_valid_b,
  input  logic [CNT_BIT_SIZE-1:0] i_count_b,
  output logic [RESP_BITS-1:0]    o_resp,
  output logic                    o_resp_valid,
  input  logic                    i_resp_ready,
  output logic                    o_tie,
  output logic                    o_timeout
);

  localparam int unsigned IdxW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int unsigned ClrW = $clog2(CLR_CYCLES + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT + 1);

  localparam logic [IdxW-1:0] IdxLast = IdxW'(RESP_BITS - 1);
  localparam logic [ClrW-1:0] ClrLast = ClrW'(CLR_CYCLES - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StClr    = 3'd1;
  localparam logic [2:0] StRun    = 3'd2;
  localparam logic [2:0] StSample = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  logic [2:0]              state_q, state_d;
  logic                    valid_a_meta_q, valid_a_sync_q;
  logic                    valid_b_meta_q, valid_b_sync_q;
  logic [ClrW-1:0]         clr_cnt_q, clr_cnt_d;
  logic [ToW-1:0]          to_cnt_q, to_cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [RESP_BITS-1:0]    sreg_q, sreg_d;
  logic [RESP_BITS-1:0]    resp_q, resp_d;
  logic                    tie_q, tie_d;
  logic                    timeout_q, timeout_d;
  logic [CNT_BIT_SIZE-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_BIT_SIZE-1:0] cnt_b_q, cnt_b_d;
  logic                    both_valid;

  // Two-flop synchronisers for the RO-domain valid flags; counts are not
  // synchronised because they are stable whenever their valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_a_meta_q <= 1'b0;
      valid_a_sync_q <= 1'b0;
      valid_b_meta_q <= 1'b0;
      valid_b_sync_q <= 1'b0;
    end else begin
      valid_a_meta_q <= i_valid_a;
      valid_a_sync_q <= valid_a_meta_q;
      valid_b_meta_q <= i_valid_b;
      valid_b_sync_q <= valid_b_meta_q;
    end
  end

  assign both_valid = valid_a_sync_q & valid_b_sync_q;

  // Next-state and datapath decode for the evaluation sequence.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    to_cnt_d  = to_cnt_q;
    idx_d     = idx_q;
    sreg_d    = sreg_q;
    resp_d    = resp_q;
    tie_d     = tie_q;
    timeout_d = 1'b0;
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d   = StClr;
          clr_cnt_d = '0;
          idx_d     = '0;
          sreg_d    = '0;
          tie_d     = 1'b0;
        end
      end

      StClr: begin
        if (clr_cnt_q == ClrLast) begin
          state_d  = StRun;
          to_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      StRun: begin
        to_cnt_d = to_cnt_q + 1'b1;
        // Valid takes priority over a coincident timeout.
        if (both_valid) begin
          state_d = StSample;
          cnt_a_d = i_count_a;
          cnt_b_d = i_count_b;
        end else if (to_cnt_q == ToLast) begin
          // Abort: partial bits are dropped, the last delivered word is kept.
          state_d   = StIdle;
          timeout_d = 1'b1;
        end
      end

      StSample: begin
        sreg_d[idx_q] = (cnt_a_q > cnt_b_q);
        if (cnt_a_q == cnt_b_q) begin
          tie_d = 1'b1;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == IdxLast) begin
          state_d = StDone;
          resp_d  = sreg_d;
        end else begin
          state_d   = StClr;
          clr_cnt_d = '0;
        end
      end

      StDone: begin
        if (i_resp_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      clr_cnt_q <= '0;
      to_cnt_q  <= '0;
      idx_q     <= '0;
      sreg_q    <= '0;
      resp_q    <= '0;
      tie_q     <= 1'b0;
      timeout_q <= 1'b0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      to_cnt_q  <= to_cnt_d;
      idx_q     <= idx_d;
      sreg_q    <= sreg_d;
      resp_q    <= resp_d;
      tie_q     <= tie_d;
      timeout_q <= timeout_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
    end
  end

  // Counters stay out of reset through SAMPLE so captured counts remain valid;
  // they are only cleared in IDLE and CLR.
  assign o_busy       = (state_q != StIdle);
  assign o_puf_en     = (state_q == StRun);
  assign o_puf_rst_n  = (state_q == StRun) | (state_q == StSample) | (state_q == StDone);
  assign o_resp       = resp_q;
  assign o_resp_valid = (state_q == StDone);
  assign o_tie        = tie_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_puf_resp_reader.sv
// Directed bench for puf_resp_reader with a behavioural model of two PUF pairs.
module tb_puf_resp_reader;

  localparam int unsigned W    = 5;
  localparam int unsigned NB   = 8;
  localparam int unsigned CLRC = 2;
  localparam int unsigned TO   = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_start = 1'b0;
  logic          o_busy, o_puf_en, o_puf_rst_n;
  logic          valid_a = 1'b0, valid_b = 1'b0;
  logic [W-1:0]  count_a = '0, count_b = '0;
  logic [NB-1:0] o_resp;
  logic          o_resp_valid;
  logic          i_resp_ready = 1'b1;
  logic          o_tie, o_timeout;

  always #5 clk = ~clk;

  puf_resp_reader #(
    .CNT_BIT_SIZE(W),
    .RESP_BITS   (NB),
    .CLR_CYCLES  (CLRC),
    .TIMEOUT     (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .o_busy      (o_busy),
    .o_puf_en    (o_puf_en),
    .o_puf_rst_n (o_puf_rst_n),
    .i_valid_a   (valid_a),
    .i_count_a   (count_a),
    .i_valid_b   (valid_b),
    .i_count_b   (count_b),
    .o_resp      (o_resp),
    .o_resp_valid(o_resp_valid),
    .i_resp_ready(i_resp_ready),
    .o_tie       (o_tie),
    .o_timeout   (o_timeout)
  );

  typedef struct {
    logic [NB-1:0][W-1:0] ca;
    logic [NB-1:0][W-1:0] cb;
    int                   da;
    int                   db;
    logic [NB-1:0]        exp_resp;
    logic                 exp_tie;
  } vec_t;

  vec_t vecs[5];

  int chk_cnt = 0;
  int pass_cnt = 0;

  // PUF model and monitor state
  logic [NB-1:0][W-1:0] mca, mcb;
  int   da = 3, db = 3;
  logic b_never = 1'b0;
  int   en_cyc = 0, en_rises = 0;
  logic en_prev = 1'b0;
  int   xfers = 0, to_pulses = 0, valid_cycles = 0;
  int   clr_len = 0, clr_runs = 0, clr_bad = 0;
  logic prev_clr = 1'b0, in_clr;
  int   va_age = 0, vb_age = 0, min_age = 1000, age;

  function automatic logic [NB*W-1:0] pk(input int e0, e1, e2, e3, e4, e5, e6, e7);
    int e[8];
    logic [NB*W-1:0] r;
    e = '{e0, e1, e2, e3, e4, e5, e6, e7};
    r = '0;
    for (int i = 0; i < 8; i++) r[i*W +: W] = W'(e[i]);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    tick;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
  endtask

  task automatic clear_counters;
    xfers = 0; to_pulses = 0; valid_cycles = 0; en_rises = 0;
    clr_runs = 0; clr_bad = 0; min_age = 1000;
  endtask

  task automatic load_model(input int k);
    mca = vecs[k].ca;
    mcb = vecs[k].cb;
    da = vecs[k].da;
    db = vecs[k].db;
    b_never = 1'b0;
  endtask

  task automatic wait_busy_low(input int bound);
    int n;
    n = 0;
    while (o_busy && n < bound) begin
      tick;
      n++;
    end
    check("busy_drops_in_time", o_busy, 0);
  endtask

  // One full word with ready held high, checked against the table entry.
  task automatic run_word(input int k);
    load_model(k);
    clear_counters();
    i_resp_ready = 1'b1;
    pulse_start();
    check("busy_after_start", o_busy, 1);
    wait_busy_low(2000);
    check("word_resp", o_resp, vecs[k].exp_resp);
    check("word_tie", o_tie, vecs[k].exp_tie);
    check("word_evaluations", en_rises, NB);
    check("word_transfers", xfers, 1);
    check("word_no_timeout", to_pulses, 0);
    check("word_clr_runs", clr_runs, NB);
    check("word_clr_len_bad", clr_bad, 0);
    check("word_sample_after_sync", min_age, 3);
  endtask

  // Monitors first (pre-update model values), then the PUF model reacts to
  // the DUT's enable/reset as seen half a cycle after the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (o_resp_valid && i_resp_ready) xfers++;
      if (o_resp_valid) valid_cycles++;
      if (o_timeout) to_pulses++;
      in_clr = o_busy && !o_puf_rst_n;
      if (in_clr) clr_len++;
      else if (prev_clr) begin
        clr_runs++;
        if (clr_len != CLRC) clr_bad++;
        clr_len = 0;
      end
      prev_clr = in_clr;
      va_age = valid_a ? va_age + 1 : 0;
      vb_age = valid_b ? vb_age + 1 : 0;
      if (en_prev && !o_puf_en && o_puf_rst_n) begin
        age = (va_age < vb_age) ? va_age : vb_age;
        if (age < min_age) min_age = age;
      end
      if (o_puf_en && !en_prev) en_rises++;
      en_prev = o_puf_en;

      if (!o_puf_rst_n) begin
        en_cyc = 0;
        valid_a = 1'b0;
        valid_b = 1'b0;
      end else if (o_puf_en) begin
        en_cyc++;
        if (en_cyc == da) begin
          count_a = mca[(en_rises - 1) % NB];
          valid_a = 1'b1;
        end
        if (en_cyc == db && !b_never) begin
          count_b = mcb[(en_rises - 1) % NB];
          valid_b = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, stable_bad;

    vecs[0] = '{ca: pk(20, 3, 9, 9, 31, 0, 15, 16), cb: pk(10, 4, 9, 2, 30, 1, 15, 17),
                da: 3, db: 3, exp_resp: 8'h19, exp_tie: 1'b1};
    vecs[1] = '{ca: pk(5, 6, 7, 8, 9, 10, 11, 12), cb: pk(0, 0, 0, 0, 0, 0, 0, 0),
                da: 3, db: 8, exp_resp: 8'hFF, exp_tie: 1'b0};
    vecs[2] = '{ca: pk(0, 0, 0, 0, 0, 0, 0, 0), cb: pk(1, 1, 1, 1, 1, 1, 1, 1),
                da: 8, db: 2, exp_resp: 8'h00, exp_tie: 1'b0};
    vecs[3] = '{ca: pk(31, 0, 31, 0, 16, 15, 1, 30), cb: pk(30, 1, 0, 31, 15, 16, 0, 31),
                da: 5, db: 4, exp_resp: 8'h55, exp_tie: 1'b0};
    vecs[4] = '{ca: pk(1, 1, 1, 1, 1, 1, 1, 7), cb: pk(0, 0, 0, 0, 0, 0, 0, 7),
                da: 4, db: 4, exp_resp: 8'h7F, exp_tie: 1'b1};
    mca = vecs[0].ca;
    mcb = vecs[0].cb;

    // Reset values
    #1 rst_n = 1'b0;
    tick;
    tick;
    check("rst_busy", o_busy, 0);
    check("rst_puf_en", o_puf_en, 0);
    check("rst_puf_rst_n", o_puf_rst_n, 0);
    check("rst_resp", o_resp, 0);
    check("rst_resp_valid", o_resp_valid, 0);
    check("rst_tie", o_tie, 0);
    check("rst_timeout", o_timeout, 0);
    rst_n = 1'b1;
    tick;

    // Table-driven words
    for (int i = 0; i < 5; i++) run_word(i);

    // Back-pressure: ready low for 10 cycles in DONE, start ignored meanwhile
    load_model(3);
    clear_counters();
    i_resp_ready = 1'b0;
    pulse_start();
    n = 0;
    while (!o_resp_valid && n < 2000) begin
      tick;
      n++;
    end
    check("bp_valid_reached", o_resp_valid, 1);
    stable_bad = 0;
    for (int c = 0; c < 10; c++) begin
      i_start = (c == 5);
      tick;
      if (!(o_resp_valid && o_resp == vecs[3].exp_resp)) stable_bad++;
    end
    i_start = 1'b0;
    check("bp_stable_cycles_bad", stable_bad, 0);
    check("bp_no_transfer_yet", xfers, 0);
    i_resp_ready = 1'b1;
    tick;
    check("bp_busy_after_xfer", o_busy, 0);
    check("bp_valid_after_xfer", o_resp_valid, 0);
    check("bp_resp_held", o_resp, vecs[3].exp_resp);
    for (int c = 0; c < 5; c++) tick;
    check("bp_start_in_done_ignored", o_busy, 0);
    check("bp_transfers", xfers, 1);
    check("bp_evaluations", en_rises, NB);

    // i_start pulsed while running is ignored
    load_model(1);
    clear_counters();
    pulse_start();
    n = 0;
    while (!o_puf_en && n < 50) begin
      tick;
      n++;
    end
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    n = 0;
    while (!(en_rises == 4 && o_puf_en) && n < 500) begin
      tick;
      n++;
    end
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    wait_busy_low(2000);
    check("run_start_evaluations", en_rises, NB);
    check("run_start_transfers", xfers, 1);
    check("run_start_resp", o_resp, vecs[1].exp_resp);
    for (int c = 0; c < 5; c++) tick;
    check("run_start_stays_idle", o_busy, 0);

    // Asynchronous reset in RUN of bit 4, then a fresh word
    load_model(4);
    clear_counters();
    pulse_start();
    n = 0;
    while (!(en_rises == 5 && o_puf_en) && n < 2000) begin
      tick;
      n++;
    end
    check("mid_rst_reached_bit4", o_puf_en, 1);
    tick;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_puf_en", o_puf_en, 0);
    check("mid_rst_puf_rst_n", o_puf_rst_n, 0);
    check("mid_rst_resp", o_resp, 0);
    check("mid_rst_tie", o_tie, 0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    run_word(0);

    // B never valid: abort after TO cycles in RUN
    load_model(0);
    b_never = 1'b1;
    clear_counters();
    pulse_start();
    n = 0;
    while (!o_puf_en && n < 50) begin
      tick;
      n++;
    end
    k = 0;
    while (!o_timeout && k < 100) begin
      tick;
      k++;
    end
    check("to_cycles_from_run", k, TO);
    check("to_busy", o_busy, 0);
    check("to_puf_en", o_puf_en, 0);
    check("to_resp_valid", o_resp_valid, 0);
    check("to_resp_kept", o_resp, vecs[0].exp_resp);
    tick;
    check("to_pulse_one_cycle", o_timeout, 0);
    check("to_pulse_count", to_pulses, 1);
    check("to_no_valid_seen", valid_cycles, 0);
    check("to_single_eval", en_rises, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
